// File: rtl/dlx_ctrl_pkg.sv
// Shared field layout, forwarding encodings and the NOP control word for the
// DLX control pipeline.
package dlx_ctrl_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int DEF_ALU_W  = 6;

    localparam int EX_CTRL_W  = 3;
    localparam int MEM_CTRL_W = 4;
    localparam int WR_CTRL_W  = 2;
    localparam int FWD_W      = 2;

    // Bit positions inside the ex/mem/wr control fields.
    localparam int EX_LINK      = 2;
    localparam int EX_LOAD_HIGH = 1;
    localparam int EX_ALU_SRC   = 0;
    localparam int MEM_SIGN     = 3;
    localparam int MEM_WR       = 2;
    localparam int MEM_SIZE_LSB = 0;
    localparam int WR_REG_WR    = 1;
    localparam int WR_WSRC      = 0;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [EX_CTRL_W-1:0]  ex;
        logic [MEM_CTRL_W-1:0] mem;
        logic [WR_CTRL_W-1:0]  wr;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // The EX/MEM result is the youngest value, so it wins over MEM/WB.
    function automatic fwd_sel_e fwd_select(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        if (mem_hit)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary register: async clear, and a bubble input that loads
// the NOP word in place of the incoming stage word.
module pipe_stage_reg #(
    parameter int           W   = 8,
    parameter logic [W-1:0] NOP = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_d;
    logic [W-1:0] stage_q;

    assign stage_d = bubble_i ? NOP : d_i;

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the pipeline shifts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_q <= NOP;
        else
            stage_q <= stage_d;
    end

    assign q_o = stage_q;

endmodule

// File: rtl/dlx_ctrl_pipe.sv
// Carries the decode control word through ID/EX, EX/MEM and MEM/WB, and
// produces the registered forwarding selects plus the load-use stall.
module dlx_ctrl_pipe
    import dlx_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int ALU_W  = DEF_ALU_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_AW-1:0]     id_rs1,
    input  logic [REG_AW-1:0]     id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_AW-1:0]     id_rw,
    input  logic [ALU_W-1:0]      id_alu_ctrl,
    input  logic [EX_CTRL_W-1:0]  id_ex_ctrl,
    input  logic [MEM_CTRL_W-1:0] id_mem_ctrl,
    input  logic [WR_CTRL_W-1:0]  id_wr_ctrl,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic [ALU_W-1:0]      ex_alu_ctrl,
    output logic [EX_CTRL_W-1:0]  ex_ex_ctrl,
    output logic [FWD_W-1:0]      ex_fwd_a,
    output logic [FWD_W-1:0]      ex_fwd_b,
    output logic                  mem_valid,
    output logic [MEM_CTRL_W-1:0] mem_mem_ctrl,
    output logic [REG_AW-1:0]     mem_rw,
    output logic                  wb_valid,
    output logic [WR_CTRL_W-1:0]  wb_wr_ctrl,
    output logic [REG_AW-1:0]     wb_rw
);

    localparam int IDEX_W  = 1 + ALU_W + $bits(ctrl_t) + REG_AW + 2 * FWD_W;
    localparam int EXMEM_W = 1 + MEM_CTRL_W + WR_CTRL_W + REG_AW;
    localparam int MEMWB_W = 1 + WR_CTRL_W + REG_AW;

    localparam logic [IDEX_W-1:0] IDEX_NOP =
        {1'b0, {ALU_W{1'b0}}, CTRL_NOP, {REG_AW{1'b0}}, FWD_RF, FWD_RF};

    ctrl_t                  id_ctrl;
    logic [MEM_CTRL_W-1:0]  ex_mem_ctrl;
    logic [WR_CTRL_W-1:0]   ex_wr_ctrl;
    logic [REG_AW-1:0]      ex_rw;
    logic [WR_CTRL_W-1:0]   mem_wr_ctrl;

    logic                   ex_writer;
    logic                   ex_load;
    logic                   mem_writer;
    logic                   load_use;
    logic                   bubble;
    fwd_sel_e               fwd_a_d;
    fwd_sel_e               fwd_b_d;

    logic [IDEX_W-1:0]      idex_d;
    logic [IDEX_W-1:0]      idex_q;
    logic [EXMEM_W-1:0]     exmem_d;
    logic [EXMEM_W-1:0]     exmem_q;
    logic [MEMWB_W-1:0]     memwb_d;
    logic [MEMWB_W-1:0]     memwb_q;

    assign id_ctrl = '{ex: id_ex_ctrl, mem: id_mem_ctrl, wr: id_wr_ctrl};

    // Register 0 is hard-wired, so a stage writing it produces nothing to forward.
    assign ex_writer  = ex_valid & ex_wr_ctrl[WR_REG_WR] & (ex_rw != '0);
    assign ex_load    = ex_writer & ex_wr_ctrl[WR_WSRC];
    assign mem_writer = mem_valid & mem_wr_ctrl[WR_REG_WR] & (mem_rw != '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value unassigned and infers a latch.
        fwd_a_d  = FWD_RF;
        fwd_b_d  = FWD_RF;
        load_use = 1'b0;
        if (id_use_rs1) begin
            fwd_a_d  = fwd_select(ex_writer & ~ex_load & (ex_rw == id_rs1),
                                  mem_writer & (mem_rw == id_rs1));
            load_use = ex_load & (ex_rw == id_rs1);
        end
        if (id_use_rs2) begin
            fwd_b_d  = fwd_select(ex_writer & ~ex_load & (ex_rw == id_rs2),
                                  mem_writer & (mem_rw == id_rs2));
            load_use = load_use | (ex_load & (ex_rw == id_rs2));
        end
    end

    // A flush squashes the consumer anyway, so it also cancels the stall.
    assign stall  = id_valid & ~flush & load_use;
    assign bubble = flush | stall | ~id_valid;

    assign idex_d = {id_valid, id_alu_ctrl, id_ctrl, id_rw, fwd_a_d, fwd_b_d};

    pipe_stage_reg #(.W(IDEX_W), .NOP(IDEX_NOP)) u_idex (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (bubble),
        .d_i      (idex_d),
        .q_o      (idex_q)
    );

    assign {ex_valid, ex_alu_ctrl, ex_ex_ctrl, ex_mem_ctrl, ex_wr_ctrl,
            ex_rw, ex_fwd_a, ex_fwd_b} = idex_q;

    // Later stages never hold; a bubble already travels as an all-zero word.
    assign exmem_d = {ex_valid, ex_mem_ctrl, ex_wr_ctrl, ex_rw};

    pipe_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (1'b0),
        .d_i      (exmem_d),
        .q_o      (exmem_q)
    );

    assign {mem_valid, mem_mem_ctrl, mem_wr_ctrl, mem_rw} = exmem_q;

    assign memwb_d = {mem_valid, mem_wr_ctrl, mem_rw};

    pipe_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (1'b0),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    assign {wb_valid, wb_wr_ctrl, wb_rw} = memwb_q;

endmodule

// File: tb/tb_dlx_ctrl_pipe.sv
// Scoreboard bench for dlx_ctrl_pipe: directed DLX sequences plus random
// traffic, checked against a register-dependency model of in-flight instructions.
module tb_dlx_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs1, id_use_rs2, flush;
    logic [4:0] id_rs1, id_rs2, id_rw;
    logic [5:0] id_alu_ctrl;
    logic [2:0] id_ex_ctrl;
    logic [3:0] id_mem_ctrl;
    logic [1:0] id_wr_ctrl;
    logic       stall, ex_valid, mem_valid, wb_valid;
    logic [5:0] ex_alu_ctrl;
    logic [2:0] ex_ex_ctrl;
    logic [1:0] ex_fwd_a, ex_fwd_b, wb_wr_ctrl;
    logic [3:0] mem_mem_ctrl;
    logic [4:0] mem_rw, wb_rw;

    always #5 clk = ~clk;

    dlx_ctrl_pipe #(.REG_AW(5), .ALU_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rw(id_rw),
        .id_alu_ctrl(id_alu_ctrl), .id_ex_ctrl(id_ex_ctrl), .id_mem_ctrl(id_mem_ctrl),
        .id_wr_ctrl(id_wr_ctrl), .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_ex_ctrl(ex_ex_ctrl), .ex_fwd_a(ex_fwd_a),
        .ex_fwd_b(ex_fwd_b), .mem_valid(mem_valid), .mem_mem_ctrl(mem_mem_ctrl),
        .mem_rw(mem_rw), .wb_valid(wb_valid), .wb_wr_ctrl(wb_wr_ctrl), .wb_rw(wb_rw)
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rw;
        logic [5:0] alu;
        logic [2:0] exc;
        logic [3:0] memc;
        logic [1:0] wrc;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] alu;
        logic [2:0] exc;
        logic [3:0] memc;
        logic [1:0] wrc;
        logic [4:0] rw;
        logic [1:0] fa, fb;
    } rec_t;

    // hist[0] is the instruction now in EX, hist[1] the one in MEM.
    rec_t   hist[$];
    rec_t   q_ex[$], q_mem[$], q_wb[$];
    rec_t   e_ex, e_mem, e_wb;
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    instr_t last_in;
    logic   last_fl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic instr_t mk_alu(input int rd, input int s1, input int s2);
        instr_t x = '0;
        x.valid = 1'b1; x.rs1 = 5'(s1); x.rs2 = 5'(s2); x.u1 = 1'b1; x.u2 = 1'b1;
        x.rw = 5'(rd); x.alu = 6'h20; x.wrc = 2'b10;
        return x;
    endfunction

    function automatic instr_t mk_alui(input int rd, input int s1);
        instr_t x = mk_alu(rd, s1, 0);
        x.u2 = 1'b0; x.exc = 3'b001; x.alu = 6'h08;
        return x;
    endfunction

    function automatic instr_t mk_load(input int rd, input int s1);
        instr_t x = mk_alui(rd, s1);
        x.memc = 4'b1010; x.wrc = 2'b11;
        return x;
    endfunction

    function automatic instr_t mk_store(input int s1, input int s2);
        instr_t x = mk_alu(0, s1, s2);
        x.exc = 3'b001; x.memc = 4'b0110; x.wrc = 2'b00;
        return x;
    endfunction

    function automatic int rreg();
        return int'($urandom_range(0, 7));
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        case ($urandom_range(0, 3))
            0: x = mk_alu(rreg(), rreg(), rreg());
            1: x = mk_load(rreg(), rreg());
            2: begin x = mk_store(rreg(), rreg()); x.rw = 5'(rreg()); end
            default: begin
                x = mk_alu(0, rreg(), rreg());
                x.u2 = 1'b0; x.wrc = 2'b00; x.exc = 3'($urandom_range(0, 7));
            end
        endcase
        x.alu = 6'($urandom_range(0, 63));
        x.memc[1:0] = 2'($urandom_range(0, 3));
        x.valid = ($urandom_range(0, 7) != 0);
        return x;
    endfunction

    // ---------------- reference model ----------------
    // A source reads the youngest older in-flight writer of its register:
    // one slot ahead gives the EX/MEM result unless it is a load (then wait a
    // cycle), two slots ahead gives the MEM/WB data, anything older is in the
    // register file.
    function automatic void src_lookup(input logic use_s, input logic [4:0] r,
                                       output logic [1:0] sel, output logic haz);
        bit found;
        found = 1'b0;
        sel = 2'b00;
        haz = 1'b0;
        if (use_s && r != 5'd0) begin
            for (int age = 0; age < hist.size(); age++) begin
                if (!found && hist[age].valid && hist[age].wrc[1] && hist[age].rw == r) begin
                    found = 1'b1;
                    if (age == 0 && hist[age].wrc[0]) haz = 1'b1;
                    else sel = (age == 0) ? 2'b01 : 2'b10;
                end
            end
        end
    endfunction

    task automatic score(input instr_t in, input logic fl, output logic st);
        logic [1:0] fa, fb;
        logic       ha, hb;
        rec_t       ent;
        src_lookup(in.u1, in.rs1, fa, ha);
        src_lookup(in.u2, in.rs2, fb, hb);
        st = in.valid && !fl && (ha || hb);
        check("stall", 64'(stall), 64'(st));
        if (!in.valid || fl || st)
            ent = '0;
        else
            ent = '{valid: 1'b1, alu: in.alu, exc: in.exc, memc: in.memc,
                    wrc: in.wrc, rw: in.rw, fa: fa, fb: fb};
        q_ex.push_back(ent);
        q_mem.push_back(ent);
        q_wb.push_back(ent);
        hist.push_front(ent);
        if (hist.size() > 2) void'(hist.pop_back());
    endtask

    // ---------------- driver ----------------
    task automatic drive(input instr_t in, input logic fl);
        id_valid = in.valid; id_rs1 = in.rs1; id_rs2 = in.rs2;
        id_use_rs1 = in.u1; id_use_rs2 = in.u2; id_rw = in.rw;
        id_alu_ctrl = in.alu; id_ex_ctrl = in.exc; id_mem_ctrl = in.memc;
        id_wr_ctrl = in.wrc; flush = fl;
        last_in = in; last_fl = fl;
    endtask

    task automatic issue(input instr_t in, input logic fl, output logic st);
        @(negedge clk);
        drive(in, fl);
        #1;
        score(in, fl, st);
    endtask

    // Re-presents a consumer while decode is told to hold (bounded).
    task automatic present(input instr_t in);
        logic st;
        int   n;
        n = 0;
        issue(in, 1'b0, st);
        while (st && n < 3) begin
            issue(in, 1'b0, st);
            n++;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive((i == cycles - 1) ? mk_alu(1, 2, 3) : rand_instr(), 1'b0);
            #1;
            check("reset_outputs",
                  64'({stall, ex_valid, ex_alu_ctrl, ex_ex_ctrl, ex_fwd_a, ex_fwd_b,
                       mem_valid, mem_mem_ctrl, mem_rw, wb_valid, wb_wr_ctrl, wb_rw}),
                  64'(0));
        end
        // Release away from the edge; the instruction on the inputs is the
        // first one captured and sees an empty pipeline ahead of it.
        rst_n = 1'b1;
        hist.delete(); q_ex.delete(); q_mem.delete(); q_wb.delete();
        q_mem.push_back('0);
        q_wb.push_back('0);
        q_wb.push_back('0);
        #1;
        begin
            logic st;
            score(last_in, last_fl, st);
        end
        mon_en = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (q_ex.size() == 0 || q_mem.size() == 0 || q_wb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: no expected word queued at %0t", $time);
            end else begin
                e_ex  = q_ex.pop_front();
                e_mem = q_mem.pop_front();
                e_wb  = q_wb.pop_front();
                check("ex_stage", 64'({ex_valid, ex_alu_ctrl, ex_ex_ctrl, ex_fwd_a, ex_fwd_b}),
                      64'({e_ex.valid, e_ex.alu, e_ex.exc, e_ex.fa, e_ex.fb}));
                check("mem_stage", 64'({mem_valid, mem_mem_ctrl, mem_rw}),
                      64'({e_mem.valid, e_mem.memc, e_mem.rw}));
                check("wb_stage", 64'({wb_valid, wb_wr_ctrl, wb_rw}),
                      64'({e_wb.valid, e_wb.wrc, e_wb.rw}));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t cur;
        logic   st;
        drive('0, 1'b0);
        do_reset(4);

        present(mk_alu(3, 1, 2));            // add r3,r1,r2
        present(mk_alu(4, 3, 1));            // sub r4,r3,r1 -> fwd_a 01
        present(mk_load(5, 1));              // lw r5,0(r1)
        present(mk_alu(6, 5, 2));            // add r6,r5,r2 -> one stall, then 10
        present(mk_alui(0, 1));              // addi r0,r1,4
        present(mk_alu(7, 0, 0));            // add r7,r0,r0 -> no forwarding
        present(mk_load(5, 1));
        issue(mk_alu(6, 5, 5), 1'b1, st);    // consumer squashed by flush
        present(mk_alu(8, 5, 1));
        present(mk_store(1, 2));             // sw r2,8(r1)
        present(mk_alu(9, 2, 0));            // does not depend on the store
        for (int i = 0; i < 3; i++) present('0);

        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            issue(cur, ($urandom_range(0, 9) == 0), st);
            if (!st) cur = rand_instr();
        end

        do_reset(3);
        cur = rand_instr();
        for (int i = 0; i < 300; i++) begin
            issue(cur, ($urandom_range(0, 9) == 0), st);
            if (!st) cur = rand_instr();
        end
        for (int i = 0; i < 3; i++) present('0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
